onehot_decoder_pipe: RTL and testbench
======================================

Name: onehot_decoder_pipe

Overview:
- Binary-to-one-hot decoder; the inverse of the team's 4x2 encoder. With IN_W=2, code {y0,y1} maps back to in0..in3.
- Accepts codes on a valid/ready input stream, decodes them and buffers the results in a 2-entry output queue.
- Sits downstream of the encoder in select/arbitration paths that need backpressure tolerance.

Parameters:
- IN_W, 2, input code width; OUT_W is derived as 1<<IN_W (localparam, not overridable). Legal range 1..5.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  input code present
- in_ready  output  1  block can accept a code this cycle
- in_code  input  IN_W  binary code; MSB is the encoder's y0
- in_en  input  1  decode enable, sampled with the code; 0 produces an all-zero word
- in_par  input  1  even parity over in_code; present only with DECODER_PARITY_CHK_EN
- out_valid  output  1  decoded word available
- out_ready  input  1  consumer accepts the word
- out_onehot  output  OUT_W  decoded word; bit k set iff in_code==k and in_en=1
- err  output  1  sticky parity error; present only with DECODER_PARITY_CHK_EN

Behaviour:
- Transfers:
  - Input transfer occurs when in_valid&&in_ready.
  - Output transfer occurs when out_valid&&out_ready.
- Decode is combinational on the input side; the result is written into the queue on the input transfer edge.
- Latency is 1 cycle: a word accepted at edge N is visible on out_valid/out_onehot after edge N when the queue was empty.
- Queue is 2 entries, strict FIFO order. State machine:
  - EMPTY: push -> ONE.
  - ONE: push and pop together -> ONE; push only -> FULL; pop only -> EMPTY.
  - FULL: pop -> ONE. Push is impossible because in_ready=0.
- in_ready = (state != FULL). It is a state decode only and has no combinational path from out_ready.
- out_valid = (state != EMPTY). out_onehot shows the head entry, and is all-zero whenever out_valid=0.
- Simultaneous push and pop in ONE: the head is replaced by the new word at that edge, with no bubble.
- Holding rules:
  - While out_valid=1 and out_ready=0, out_onehot stays stable.
  - in_code and in_en are don't-care when in_valid=0.
- Reset (asynchronous, any time including mid-transfer):
  - state=EMPTY, both entries cleared to 0, out_valid=0, out_onehot=0, in_ready=1, err=0.
  - A transfer coinciding with the reset assertion is dropped.
- in_en=0 with in_valid=1 still consumes a queue slot and emits an all-zero word. This mirrors the encoder's "no input" case.
- Exactly one bit of out_onehot is set for every in_en=1 word. Out-of-range codes cannot occur because OUT_W=2^IN_W.

Optional Feature:
- DECODER_PARITY_CHK_EN:
  - When defined, the in_par and err ports exist.
  - An accepted word whose in_par != ^in_code is enqueued as all-zero.
  - err sets on the edge after that transfer and stays set until reset.
- When undefined, neither port exists and parity is never checked.

Decomposition:
- Package decoder_pkg holds:
  - the queue state enum (EMPTY, ONE, FULL) as a 2-bit typedef;
  - a function returning 1<<w for OUT_W;
  - a constant holding the max IN_W of 5.
- Sub-module onehot_decoder_core: purely combinational in_code/in_en -> OUT_W one-hot, parameterised by IN_W. The pipe instantiates it once on the input side.

Test Plan:
- Reset, then push codes 0,1,2,3 (in_en=1) with out_ready=1 held -> out_onehot 4'b0001, 0010, 0100, 1000 on consecutive cycles, each one cycle after its push; in_ready stays 1.
- out_ready=0, push codes 3 then 1 -> in_ready drops to 0 after the 2nd push. A 3rd push of code 2 is held off. Release out_ready -> outputs 1000, 0010, then 0100 in order, with no loss or duplication.
- Queue at ONE, push and pop in the same cycle (head 0100, new code 0) -> next cycle out_onehot=0001, out_valid=1, state remains ONE.
- Push code 2 with in_en=0 -> out_valid=1 with out_onehot=0000; slot consumed.
- Queue FULL, assert rst_n=0 mid-cycle -> out_valid=0, out_onehot=0 and in_ready=1 immediately without a clock. After release, the first push of code 1 yields 0010.
- With DECODER_PARITY_CHK_EN: push code 3 with in_par=1 -> out_onehot=0000 and err=1 the next cycle. A following correct push of code 3 with in_par=0 gives 1000 while err stays 1.

Source files
------------

// File: rtl/onehot_decoder_pipe_pkg.sv
// rtl/onehot_decoder_pipe_pkg.sv - shared types and helpers for the one-hot decoder pipe
//
// Package decoder_pkg:
//   q_state_t     - 2-entry output queue occupancy (EMPTY, ONE, FULL)
//   IN_W_MAX      - largest supported code width
//   onehot_width  - returns 1<<w, the decoded word width for a w-bit code
package decoder_pkg;

  localparam int unsigned IN_W_MAX = 5;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } q_state_t;

  function automatic int unsigned onehot_width(input int unsigned w);
    return 32'd1 << w;
  endfunction

endpackage

// File: rtl/onehot_decoder_pipe_if.sv
// rtl/onehot_decoder_pipe_if.sv - input/output stream bundle of the one-hot decoder pipe
//
// Optional feature macro: DECODER_PARITY_CHK_EN (adds in_par and err)
// Signals:
//   in_valid/in_ready  input stream handshake
//   in_code [IN_W]     binary code, MSB is the encoder's y0
//   in_en              decode enable, 0 gives an all-zero word
//   in_par             even parity over in_code (parity build only)
//   out_valid/out_ready output stream handshake
//   out_onehot [OUT_W] decoded head-of-queue word
//   err                sticky parity error (parity build only)
// Modports: master = producer/consumer side (bench), slave = decoder side.
interface onehot_decoder_pipe_if #(
  parameter int IN_W = 2
);
  import decoder_pkg::*;

  localparam int unsigned OUT_W = onehot_width(IN_W);

  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_code;
  logic             in_en;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_onehot;
`ifdef DECODER_PARITY_CHK_EN
  logic             in_par;
  logic             err;
`endif

  modport master (
    output in_valid,
    output in_code,
    output in_en,
`ifdef DECODER_PARITY_CHK_EN
    output in_par,
    input  err,
`endif
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_onehot
  );

  modport slave (
    input  in_valid,
    input  in_code,
    input  in_en,
`ifdef DECODER_PARITY_CHK_EN
    input  in_par,
    output err,
`endif
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_onehot
  );

endinterface

// File: rtl/onehot_decoder_pipe_core.sv
// rtl/onehot_decoder_pipe_core.sv - combinational binary to one-hot decode
//
// Module onehot_decoder_core:
//   code   [IN_W]  in   binary code
//   en             in   decode enable; 0 forces an all-zero word
//   onehot [OUT_W] out  bit k set iff code==k and en=1
module onehot_decoder_core
  import decoder_pkg::*;
#(
  parameter int IN_W = 2
) (
  input  logic [IN_W-1:0]                 code,
  input  logic                            en,
  output logic [onehot_width(IN_W)-1:0]   onehot
);

  always_comb begin
    onehot = '0;
    // OUT_W = 2^IN_W, so every code value indexes a real bit.
    if (en) onehot[code] = 1'b1;
  end

endmodule

// File: rtl/onehot_decoder_pipe.sv
// rtl/onehot_decoder_pipe.sv - one-hot decoder with 2-entry output queue
//
// Optional feature macro: DECODER_PARITY_CHK_EN (parity check on in_code,
// mismatching words are enqueued as zero and a sticky err is raised).
// Ports:
//   clk    in  rising-edge clock
//   rst_n  in  asynchronous active-low reset
//   bus    onehot_decoder_pipe_if.slave - input and output streams
// in_ready depends only on queue state; output is head-of-queue, zero when empty.
module onehot_decoder_pipe
  import decoder_pkg::*;
#(
  parameter int IN_W = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  onehot_decoder_pipe_if.slave     bus
);

  localparam int unsigned OUT_W = onehot_width(IN_W);

  q_state_t         state, state_next;
  logic [OUT_W-1:0] q0, q0_next;   // head entry
  logic [OUT_W-1:0] q1, q1_next;   // second entry, only meaningful in FULL
  logic [OUT_W-1:0] dec_word;
  logic [OUT_W-1:0] word;
  logic             push;
  logic             pop;

  onehot_decoder_core #(
    .IN_W (IN_W)
  ) u_core (
    .code   (bus.in_code),
    .en     (bus.in_en),
    .onehot (dec_word)
  );

  assign bus.in_ready  = (state != FULL);
  assign bus.out_valid = (state != EMPTY);
  assign bus.out_onehot = (state != EMPTY) ? q0 : '0;

  assign push = bus.in_valid && bus.in_ready;
  assign pop  = bus.out_valid && bus.out_ready;

`ifdef DECODER_PARITY_CHK_EN
  logic par_bad;
  logic err_q;

  assign par_bad = (bus.in_par != ^bus.in_code);
  assign word    = par_bad ? '0 : dec_word;
  assign bus.err = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (push && par_bad) begin
      err_q <= 1'b1;
    end
  end
`else
  assign word = dec_word;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
      q0    <= '0;
      q1    <= '0;
    end else begin
      state <= state_next;
      q0    <= q0_next;
      q1    <= q1_next;
    end
  end

  always_comb begin
    state_next = state;
    q0_next    = q0;
    q1_next    = q1;
    case (state)
      EMPTY: begin
        if (push) begin
          q0_next    = word;
          state_next = ONE;
        end
      end
      ONE: begin
        if (push && pop) begin
          // Head leaves and the new word takes its place: no bubble.
          q0_next = word;
        end else if (push) begin
          q1_next    = word;
          state_next = FULL;
        end else if (pop) begin
          q0_next    = '0;
          state_next = EMPTY;
        end
      end
      FULL: begin
        // in_ready is low here, so only a pop can happen.
        if (pop) begin
          q0_next    = q1;
          q1_next    = '0;
          state_next = ONE;
        end
      end
      default: begin
        state_next = EMPTY;
        q0_next    = '0;
        q1_next    = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_onehot_decoder_pipe.sv
// tb/tb_onehot_decoder_pipe.sv - directed self-checking bench for onehot_decoder_pipe
module tb_onehot_decoder_pipe;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  onehot_decoder_pipe_if #(.IN_W(2)) bus ();

  onehot_decoder_pipe #(.IN_W(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] c, input logic e);
    bus.in_valid = v;
    bus.in_code  = c;
    bus.in_en    = e;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    drive(1'b0, 2'd0, 1'b0);
    bus.out_ready = 1'b0;
`ifdef DECODER_PARITY_CHK_EN
    bus.in_par = 1'b0;
`endif
    #12;
    check("rst_valid", bus.out_valid, 0);
    check("rst_onehot", bus.out_onehot, 0);
    check("rst_ready", bus.in_ready, 1);
`ifdef DECODER_PARITY_CHK_EN
    check("rst_err", bus.err, 0);
`endif
    rst_n = 1'b1;
    @(negedge clk);

    // Streaming codes 0..3 with out_ready held high.
    bus.out_ready = 1'b1;
    drive(1'b1, 2'd0, 1'b1); tick();
    check("s0_valid", bus.out_valid, 1);
    check("s0_onehot", bus.out_onehot, 4'b0001);
    check("s0_ready", bus.in_ready, 1);
    drive(1'b1, 2'd1, 1'b1); tick();
    check("s1_onehot", bus.out_onehot, 4'b0010);
    check("s1_ready", bus.in_ready, 1);
    drive(1'b1, 2'd2, 1'b1); tick();
    check("s2_onehot", bus.out_onehot, 4'b0100);
    drive(1'b1, 2'd3, 1'b1); tick();
    check("s3_onehot", bus.out_onehot, 4'b1000);
    check("s3_ready", bus.in_ready, 1);
    drive(1'b0, 2'd0, 1'b0); tick();
    check("s_drain_valid", bus.out_valid, 0);
    check("s_drain_onehot", bus.out_onehot, 0);

    // Backpressure: fill with 3 then 1, hold off code 2, then release.
    bus.out_ready = 1'b0;
    drive(1'b1, 2'd3, 1'b1); tick();
    check("bp_first_ready", bus.in_ready, 1);
    check("bp_first_onehot", bus.out_onehot, 4'b1000);
    drive(1'b1, 2'd1, 1'b1); tick();
    check("bp_full_ready", bus.in_ready, 0);
    check("bp_full_onehot", bus.out_onehot, 4'b1000);
    drive(1'b1, 2'd2, 1'b1); tick();
    check("bp_held_ready", bus.in_ready, 0);
    check("bp_held_onehot", bus.out_onehot, 4'b1000);
    bus.out_ready = 1'b1; tick();
    check("bp_out2_onehot", bus.out_onehot, 4'b0010);
    check("bp_out2_ready", bus.in_ready, 1);
    tick();
    check("bp_out3_onehot", bus.out_onehot, 4'b0100);
    check("bp_out3_valid", bus.out_valid, 1);
    drive(1'b0, 2'd0, 1'b0); tick();
    check("bp_empty_valid", bus.out_valid, 0);

    // Push and pop together in ONE: head 0100 replaced by 0001.
    bus.out_ready = 1'b0;
    drive(1'b1, 2'd2, 1'b1); tick();
    check("pp_head", bus.out_onehot, 4'b0100);
    bus.out_ready = 1'b1;
    drive(1'b1, 2'd0, 1'b1); tick();
    check("pp_new_onehot", bus.out_onehot, 4'b0001);
    check("pp_valid", bus.out_valid, 1);
    check("pp_ready", bus.in_ready, 1);
    drive(1'b0, 2'd0, 1'b0); tick();
    check("pp_empty_valid", bus.out_valid, 0);

    // in_en=0 still consumes a slot and yields a zero word.
    bus.out_ready = 1'b0;
    drive(1'b1, 2'd2, 1'b0); tick();
    check("en0_valid", bus.out_valid, 1);
    check("en0_onehot", bus.out_onehot, 4'b0000);
    drive(1'b1, 2'd1, 1'b1); tick();
    check("en0_slot_ready", bus.in_ready, 0);
    check("en0_head_stable", bus.out_onehot, 4'b0000);
    drive(1'b0, 2'd3, 1'b1); tick();
    check("en0_hold_valid", bus.out_valid, 1);

    // Asynchronous reset while FULL.
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", bus.out_valid, 0);
    check("arst_onehot", bus.out_onehot, 0);
    check("arst_ready", bus.in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    drive(1'b1, 2'd1, 1'b1); tick();
    check("arst_push_onehot", bus.out_onehot, 4'b0010);
    check("arst_push_valid", bus.out_valid, 1);
    drive(1'b0, 2'd0, 1'b0); tick();
    check("arst_drain_valid", bus.out_valid, 0);

`ifdef DECODER_PARITY_CHK_EN
    // Code 3 has even parity 0; in_par=1 is a mismatch.
    bus.out_ready = 1'b1;
    drive(1'b1, 2'd3, 1'b1);
    bus.in_par = 1'b1; tick();
    check("par_bad_onehot", bus.out_onehot, 4'b0000);
    check("par_bad_valid", bus.out_valid, 1);
    check("par_err_set", bus.err, 1);
    bus.in_par = 1'b0; tick();
    check("par_good_onehot", bus.out_onehot, 4'b1000);
    check("par_err_sticky", bus.err, 1);
    drive(1'b0, 2'd0, 1'b0); tick();
    check("par_err_hold", bus.err, 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
